// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: tag/value widths,
// producer IDs, the buffered result entry and the round-robin index helper.
package cdb_arbiter_pkg;

  localparam int TAG_W = 3;
  localparam int VAL_W = 32;
  localparam int SRC_W = 2;

  localparam logic [TAG_W-1:0] NO_TAG = 3'd0;

  localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
  localparam logic [SRC_W-1:0] SRC_MEM = 2'd1;
  localparam logic [SRC_W-1:0] SRC_BRU = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0] num;
    logic [VAL_W-1:0] value;
    logic             branch;
  } cdb_entry_t;

  // Producer index reached 'offset' steps after 'last', wrapping at n.
  function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] last,
                                                input int unsigned       offset,
                                                input int unsigned       n);
    logic [31:0] sum;
    sum = (32'(last) + offset) % n;
    return sum[SRC_W-1:0];
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer skid buffer: circular FIFO of result entries with a
// synchronous clear used for pipeline flushes.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  cdb_entry_t       push_data,
  input  logic             pop,
  output cdb_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head      = mem_q[rd_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end else begin
      end
      if (pop_ok_s) begin
        rd_d = ptr_inc(rd_q);
      end else begin
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: each producer feeds a skid FIFO, one head per
// cycle is granted round-robin and registered onto the broadcast bus.
// Build option CDB_BYPASS_EN lets a request into an empty FIFO compete and
// broadcast at its own acceptance edge instead of being buffered first.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*TAG_W-1:0] req_num,
  input  logic [NREQ*VAL_W-1:0] req_value,
  input  logic [NREQ-1:0]       req_branch,
  output logic [TAG_W-1:0]      cdb_num,
  output logic [VAL_W-1:0]      cdb_value,
  output logic                  cdb_is_branch,
  output logic [SRC_W-1:0]      cdb_src
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  cdb_entry_t       in_entry_s [NREQ];
  cdb_entry_t       head_s     [NREQ];
  logic [CNT_W-1:0] count_s    [NREQ];
  logic [NREQ-1:0]  full_s;
  logic [NREQ-1:0]  empty_s;
  logic [NREQ-1:0]  take_s;
  logic [NREQ-1:0]  sel_s;
  logic [NREQ-1:0]  push_s;
  logic [NREQ-1:0]  pop_s;
  logic [NREQ-1:0]  cand_s;

  logic             grant_vld_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic [SRC_W-1:0] idx_s;
  cdb_entry_t       grant_entry_s;

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] cdb_num_q, cdb_num_d;
  logic [VAL_W-1:0] cdb_value_q, cdb_value_d;
  logic             cdb_branch_q, cdb_branch_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_src
      assign in_entry_s[gi] = {req_num[gi*TAG_W +: TAG_W],
                               req_value[gi*VAL_W +: VAL_W],
                               req_branch[gi]};

      // Ready comes from registered occupancy only; a full FIFO never
      // passes a result straight through in the same cycle.
      assign req_ready[gi] = (count_s[gi] < CNT_W'(FIFO_DEPTH)) && !flush && !rst;

      // Zero tags complete the handshake but are never stored.
      assign take_s[gi] = req_valid[gi] && req_ready[gi] &&
                          (req_num[gi*TAG_W +: TAG_W] != NO_TAG);

      assign sel_s[gi] = grant_vld_s && (grant_idx_s == SRC_W'(gi));
      assign pop_s[gi] = sel_s[gi] && !empty_s[gi] && !flush;
`ifdef CDB_BYPASS_EN
      // A bypassed winner goes straight to the bus and skips the FIFO.
      assign push_s[gi] = take_s[gi] && !(sel_s[gi] && empty_s[gi]);
`else
      assign push_s[gi] = take_s[gi];
`endif

      cdb_src_fifo #(
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (push_s[gi] && !full_s[gi]),
        .push_data (in_entry_s[gi]),
        .pop       (pop_s[gi]),
        .head      (head_s[gi]),
        .count     (count_s[gi]),
        .full      (full_s[gi]),
        .empty     (empty_s[gi])
      );
    end
  endgenerate

  // Which producers may compete for the bus this cycle.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef CDB_BYPASS_EN
      cand_s[i] = !empty_s[i] || take_s[i];
`else
      cand_s[i] = !empty_s[i];
`endif
    end
  end

  // Round-robin search starting one past the last granted producer.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = ptr_q;
    idx_s       = ptr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx_s = rr_index(ptr_q, k, NREQ);
      if (!grant_vld_s && cand_s[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = idx_s;
      end else begin
      end
    end
  end

  // Data of the winner: FIFO head, or the live request when bypassing.
  always_comb begin
    grant_entry_s = head_s[grant_idx_s];
`ifdef CDB_BYPASS_EN
    if (empty_s[grant_idx_s]) begin
      grant_entry_s = in_entry_s[grant_idx_s];
    end else begin
    end
`endif
  end

  // Bus and pointer next-state: flush beats grant; an idle bus keeps value/src.
  always_comb begin
    ptr_d        = ptr_q;
    cdb_num_d    = NO_TAG;
    cdb_branch_d = 1'b0;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    if (flush) begin
      ptr_d = SRC_ALU;
    end else if (grant_vld_s) begin
      ptr_d        = grant_idx_s;
      cdb_num_d    = grant_entry_s.num;
      cdb_value_d  = grant_entry_s.value;
      cdb_branch_d = grant_entry_s.branch;
      cdb_src_d    = grant_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Broadcast register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= SRC_ALU;
      cdb_num_q    <= NO_TAG;
      cdb_value_q  <= 32'd0;
      cdb_branch_q <= 1'b0;
      cdb_src_q    <= SRC_ALU;
    end else begin
      ptr_q        <= ptr_d;
      cdb_num_q    <= cdb_num_d;
      cdb_value_q  <= cdb_value_d;
      cdb_branch_q <= cdb_branch_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_num       = cdb_num_q;
  assign cdb_value     = cdb_value_q;
  assign cdb_is_branch = cdb_branch_q;
  assign cdb_src       = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter in its default build (no bypass).
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [8:0]  req_num;
  logic [95:0] req_value;
  logic [2:0]  req_branch;
  logic [2:0]  cdb_num;
  logic [31:0] cdb_value;
  logic        cdb_is_branch;
  logic [1:0]  cdb_src;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int exp_src [6];

  cdb_arbiter #(
    .NREQ       (3),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_num       (req_num),
    .req_value     (req_value),
    .req_branch    (req_branch),
    .cdb_num       (cdb_num),
    .cdb_value     (cdb_value),
    .cdb_is_branch (cdb_is_branch),
    .cdb_src       (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [2:0] num, input logic [31:0] val, input logic br);
    req_valid[i]        = 1'b1;
    req_num[i*3 +: 3]   = num;
    req_value[i*32 +: 32] = val;
    req_branch[i]       = br;
  endtask

  task automatic idle(input int i);
    req_valid[i]          = 1'b0;
    req_num[i*3 +: 3]     = 3'd0;
    req_value[i*32 +: 32] = 32'd0;
    req_branch[i]         = 1'b0;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) idle(i);
  endtask

  initial begin
    exp_src = '{1, 2, 0, 1, 2, 0};
    rst   = 1'b1;
    flush = 1'b0;
    req_valid = 3'd0; req_num = 9'd0; req_value = 96'd0; req_branch = 3'd0;

    // Reset state, before and after a clock edge
    #2;
    check("rst_num", 32'(cdb_num), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    step();
    check("rst_value", cdb_value, 32'd0);
    check("rst_branch", 32'(cdb_is_branch), 32'd0);
    check("rst_src", 32'(cdb_src), 32'd0);
    check("rst_ready2", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd7);

    // Single ALU result: one edge to enqueue, next edge to broadcast
    drive(0, 3'd3, 32'h0000_002A, 1'b0);
    step();
    check("alu_lat_not_yet", 32'(cdb_num), 32'd0);
    idle(0);
    step();
    check("alu_num", 32'(cdb_num), 32'd3);
    check("alu_value", cdb_value, 32'h2A);
    check("alu_src", 32'(cdb_src), 32'd0);
    check("alu_branch", 32'(cdb_is_branch), 32'd0);
    step();
    check("alu_one_cycle", 32'(cdb_num), 32'd0);
    check("alu_value_hold", cdb_value, 32'h2A);

    // BRU branch result, not taken
    drive(2, 3'd6, 32'd0, 1'b1);
    step();
    idle(2);
    step();
    check("bru_num", 32'(cdb_num), 32'd6);
    check("bru_branch", 32'(cdb_is_branch), 32'd1);
    check("bru_value", cdb_value, 32'd0);
    check("bru_src", 32'(cdb_src), 32'd2);
    step();
    check("bru_idle_num", 32'(cdb_num), 32'd0);
    check("bru_idle_branch", 32'(cdb_is_branch), 32'd0);
    check("bru_src_hold", 32'(cdb_src), 32'd2);

    // Zero tag is accepted but never stored nor broadcast
    drive(0, 3'd0, 32'h55, 1'b0);
    step();
    step();
    check("zero_tag_ready", 32'(req_ready), 32'd7);
    idle(0);
    step();
    check("zero_tag_num", 32'(cdb_num), 32'd0);
    check("zero_tag_value", cdb_value, 32'd0);
    check("zero_tag_src", 32'(cdb_src), 32'd2);

    // All producers valid every cycle, pointer 0 -> order 1,2,0,1,2,0
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 3'd1, 32'h100, 1'b0);
    drive(1, 3'd2, 32'h101, 1'b0);
    drive(2, 3'd3, 32'h102, 1'b0);
    step();
    check("rr_first_edge", 32'(cdb_num), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rr_src_%0d", k), 32'(cdb_src), 32'(exp_src[k]));
      check($sformatf("rr_num_%0d", k), 32'(cdb_num), 32'(exp_src[k] + 1));
      if (k == 0) check("rr_ready_e1", 32'(req_ready), 32'd2);
    end
    idle_all();

    // Flush with buffered results and same-cycle requests
    drive(0, 3'd7, 32'h700, 1'b0);
    drive(1, 3'd7, 32'h701, 1'b0);
    drive(2, 3'd7, 32'h702, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_ready_low", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    idle_all();
    check("flush_num", 32'(cdb_num), 32'd0);
    #1;
    check("flush_ready_back", 32'(req_ready), 32'd7);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("flush_quiet_%0d", k), 32'(cdb_num), 32'd0);
    end

    // MEM fills while BRU and ALU win; tags 4 then 5 in order
    drive(1, 3'd7, 32'h77, 1'b0);
    step();
    idle(1);
    step();
    check("mem_pre_num", 32'(cdb_num), 32'd7);
    check("mem_pre_src", 32'(cdb_src), 32'd1);
    drive(0, 3'd1, 32'h11, 1'b0);
    drive(1, 3'd4, 32'h44, 1'b0);
    drive(2, 3'd2, 32'h22, 1'b0);
    step();
    check("mem_e0_num", 32'(cdb_num), 32'd0);
    idle(0);
    idle(2);
    drive(1, 3'd5, 32'h55, 1'b0);
    step();
    idle(1);
    check("mem_e1_num", 32'(cdb_num), 32'd2);
    check("mem_e1_src", 32'(cdb_src), 32'd2);
    check("mem_full_ready", 32'(req_ready), 32'd5);
    step();
    check("mem_e2_num", 32'(cdb_num), 32'd1);
    check("mem_e2_src", 32'(cdb_src), 32'd0);
    step();
    check("mem_e3_num", 32'(cdb_num), 32'd4);
    check("mem_e3_value", cdb_value, 32'h44);
    step();
    check("mem_e4_num", 32'(cdb_num), 32'd5);
    check("mem_e4_value", cdb_value, 32'h55);
    check("mem_e4_src", 32'(cdb_src), 32'd1);
    step();
    check("mem_done", 32'(cdb_num), 32'd0);

    // Pointer holds through idle cycles: last grant MEM, so BRU beats ALU
    step();
    step();
    drive(0, 3'd3, 32'h33, 1'b0);
    drive(2, 3'd6, 32'h66, 1'b0);
    step();
    idle_all();
    step();
    check("ptr_hold_num1", 32'(cdb_num), 32'd6);
    check("ptr_hold_src1", 32'(cdb_src), 32'd2);
    step();
    check("ptr_hold_num2", 32'(cdb_num), 32'd3);
    check("ptr_hold_src2", 32'(cdb_src), 32'd0);
    step();

    // Asynchronous reset in the middle of a broadcast
    drive(0, 3'd5, 32'h5, 1'b0);
    step();
    drive(0, 3'd4, 32'h4, 1'b0);
    drive(2, 3'd2, 32'h2, 1'b0);
    step();
    idle_all();
    check("pre_rst_num", 32'(cdb_num), 32'd5);
    rst = 1'b1;
    #1;
    check("async_rst_num", 32'(cdb_num), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    check("async_rst_value", cdb_value, 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_rst_quiet_%0d", k), 32'(cdb_num), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
